// File: rtl/data_cache_if.sv
// Client and DDR2 signal bundle for the data cache.
// The slave modport is the cache's view; the master modport is the view of
// whatever drives the client requests and models the memory controller.
interface data_cache_if;
  logic [26:0]  addr;
  logic [31:0]  write_data;
  logic         write;
  logic         enable;
  logic [31:0]  read_data;
  logic         available;
  logic         ddr2_available;
  logic [127:0] ddr2_data;
  logic [26:0]  ddr2_addr;
  logic [127:0] to_ddr2_data;
  logic         ddr2_enable;
  logic         ddr2_read;

  modport slave (
    input  addr, write_data, write, enable, ddr2_available, ddr2_data,
    output read_data, available, ddr2_addr, to_ddr2_data, ddr2_enable, ddr2_read
  );

  modport master (
    output addr, write_data, write, enable, ddr2_available, ddr2_data,
    input  read_data, available, ddr2_addr, to_ddr2_data, ddr2_enable, ddr2_read
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 32-bit word client,
// 128-bit line DDR2 side, one outstanding request at a time.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | accepting requests; hits complete here in one cycle
// WRITEBACK | dirty victim line strobed out to memory (one cycle)
// FILL_REQ  | line fill command strobed to memory (one cycle)
// FILL_WAIT | waiting for ddr2_available, then install the line
// RESPOND   | available pulse for a miss, then back to IDLE
module data_cache #(
  parameter int INDEX_BITS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  data_cache_if.slave  bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 23 - INDEX_BITS;

  typedef enum logic [2:0] {IDLE, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND} state_t;

  state_t              state_q, state_d;
  logic [26:2]         req_addr_q, req_addr_d;
  logic                req_write_q, req_write_d;
  logic [31:0]         req_wdata_q, req_wdata_d;
  logic [31:0]         read_data_q, read_data_d;
  logic                available_q, available_d;
  logic                ddr2_enable_q, ddr2_enable_d;
  logic                ddr2_read_q, ddr2_read_d;
  logic [26:0]         ddr2_addr_q, ddr2_addr_d;
  logic [127:0]        to_ddr2_data_q, to_ddr2_data_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];

  logic                mem_we, tag_we;
  logic [INDEX_BITS-1:0] mem_idx;
  logic [127:0]        mem_line;

  // Incoming request fields (used in IDLE) and captured request fields.
  logic [INDEX_BITS-1:0] in_idx, rq_idx;
  logic [TAG_BITS-1:0]   in_tag, rq_tag;
  logic [1:0]            in_word, rq_word;
  logic                  hit;

  assign in_idx  = bus.addr[INDEX_BITS+3:4];
  assign in_tag  = bus.addr[26:INDEX_BITS+4];
  assign in_word = bus.addr[3:2];
  assign rq_idx  = req_addr_q[INDEX_BITS+3:4];
  assign rq_tag  = req_addr_q[26:INDEX_BITS+4];
  assign rq_word = req_addr_q[3:2];
  assign hit     = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);

  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [1:0]   w,
                                              input logic [31:0]  d);
    logic [127:0] r;
    r = line;
    r[{w, 5'b0} +: 32] = d;
    return r;
  endfunction

  // Next-state, next-output and array write-port decode.
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_write_d    = req_write_q;
    req_wdata_d    = req_wdata_q;
    read_data_d    = read_data_q;
    available_d    = 1'b0;
    ddr2_enable_d  = 1'b0;
    ddr2_read_d    = ddr2_read_q;
    ddr2_addr_d    = ddr2_addr_q;
    to_ddr2_data_d = to_ddr2_data_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    mem_we         = 1'b0;
    tag_we         = 1'b0;
    mem_idx        = rq_idx;
    mem_line       = '0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          req_addr_d  = bus.addr[26:2];
          req_write_d = bus.write;
          req_wdata_d = bus.write_data;
          if (hit) begin
            available_d = 1'b1;
            if (bus.write) begin
              mem_we          = 1'b1;
              mem_idx         = in_idx;
              mem_line        = merge_word(data_mem[in_idx], in_word, bus.write_data);
              dirty_d[in_idx] = 1'b1;
            end else begin
              read_data_d = data_mem[in_idx][{in_word, 5'b0} +: 32];
            end
          end else if (valid_q[in_idx] && dirty_q[in_idx]) begin
            // Outputs are registered, so the WRITEBACK strobe is loaded now.
            state_d        = WRITEBACK;
            ddr2_enable_d  = 1'b1;
            ddr2_read_d    = 1'b0;
            ddr2_addr_d    = {tag_mem[in_idx], in_idx, 4'b0};
            to_ddr2_data_d = data_mem[in_idx];
          end else begin
            state_d       = FILL_REQ;
            ddr2_enable_d = 1'b1;
            ddr2_read_d   = 1'b1;
            ddr2_addr_d   = {in_tag, in_idx, 4'b0};
          end
        end
      end
      WRITEBACK: begin
        state_d       = FILL_REQ;
        ddr2_enable_d = 1'b1;
        ddr2_read_d   = 1'b1;
        ddr2_addr_d   = {rq_tag, rq_idx, 4'b0};
      end
      FILL_REQ: begin
        state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (bus.ddr2_available) begin
          mem_we          = 1'b1;
          tag_we          = 1'b1;
          mem_line        = req_write_q ? merge_word(bus.ddr2_data, rq_word, req_wdata_q)
                                        : bus.ddr2_data;
          valid_d[rq_idx] = 1'b1;
          dirty_d[rq_idx] = req_write_q;
          if (!req_write_q) read_data_d = bus.ddr2_data[{rq_word, 5'b0} +: 32];
          available_d     = 1'b1;
          state_d         = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, request capture, registered outputs and line flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_addr_q     <= '0;
      req_write_q    <= 1'b0;
      req_wdata_q    <= '0;
      read_data_q    <= '0;
      available_q    <= 1'b0;
      ddr2_enable_q  <= 1'b0;
      ddr2_read_q    <= 1'b0;
      ddr2_addr_q    <= '0;
      to_ddr2_data_q <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      req_write_q    <= req_write_d;
      req_wdata_q    <= req_wdata_d;
      read_data_q    <= read_data_d;
      available_q    <= available_d;
      ddr2_enable_q  <= ddr2_enable_d;
      ddr2_read_q    <= ddr2_read_d;
      ddr2_addr_q    <= ddr2_addr_d;
      to_ddr2_data_q <= to_ddr2_data_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
    end
  end

  // Tag and data arrays are plain storage; validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_idx] <= mem_line;
    if (tag_we) tag_mem[mem_idx]  <= rq_tag;
  end

  assign bus.read_data    = read_data_q;
  assign bus.available    = available_q;
  assign bus.ddr2_enable  = ddr2_enable_q;
  assign bus.ddr2_read    = ddr2_read_q;
  assign bus.ddr2_addr    = ddr2_addr_q;
  assign bus.to_ddr2_data = to_ddr2_data_q;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus random traffic, checked by
// a scoreboard against an architectural memory / directory model.
module tb_data_cache;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_cache_if bus();
  data_cache #(.INDEX_BITS(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit         is_load;
    bit [31:0]  data;
    int         kind;        // 0 hit, 1 clean miss, 2 dirty miss
    bit [26:0]  wb_addr;
    bit [127:0] wb_line;
    bit [26:0]  fill_addr;
    int         accept_cyc;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  int          cyc = 0;

  // Reference model: architectural word values, expected memory contents,
  // and which line each index holds.
  bit [31:0]   ref_mem [bit [24:0]];
  bit [31:0]   exp_mem [bit [24:0]];
  bit          dir_v   [1024];
  bit          dir_d   [1024];
  bit [12:0]   dir_tag [1024];

  // Memory controller model (contents only updated by observed write-backs).
  bit [127:0]  ddr_mem [bit [22:0]];
  int          mem_delay  = 0;
  bit          mem_sticky = 0;
  bit          pending    = 0;
  int          pend_cnt   = 0;
  bit [26:0]   fill_addr_obs = '0;
  bit [26:0]   wb_addr_obs   = '0;
  int          n_wb = 0;
  int          n_fill = 0;
  bit          prev_avail = 0;

  always @(posedge clk) cyc++;

  function automatic bit [31:0] init_pat(input bit [24:0] wa);
    return {wa[15:0], wa[24:9]} ^ 32'hA5C3_1E07;
  endfunction

  function automatic bit [31:0] ref_word(input bit [24:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_pat(wa);
  endfunction

  function automatic bit [31:0] exp_word(input bit [24:0] wa);
    return exp_mem.exists(wa) ? exp_mem[wa] : init_pat(wa);
  endfunction

  function automatic bit [127:0] ddr_line(input bit [22:0] la);
    bit [127:0] l;
    if (ddr_mem.exists(la)) return ddr_mem[la];
    for (int w = 0; w < 4; w++) l[32*w +: 32] = init_pat({la, 2'(w)});
    return l;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // Memory responder and completion monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pending = 0;
      n_wb = 0;
      n_fill = 0;
      prev_avail = 0;
      if (!mem_sticky) bus.ddr2_available = 1'b0;
    end else begin
      if (bus.ddr2_enable) begin
        chk("ddr2_addr_align", bus.ddr2_addr[3:0], 4'h0);
        if (bus.ddr2_read) begin
          n_fill++;
          fill_addr_obs = bus.ddr2_addr;
          pending  = 1;
          pend_cnt = mem_delay;
          if (!mem_sticky) bus.ddr2_available = 1'b0;
        end else begin
          n_wb++;
          wb_addr_obs = bus.ddr2_addr;
          if (sb.size() > 0) chk("wb_line", bus.to_ddr2_data, sb[0].wb_line);
          else fail("wb_unexpected", "write-back with no request pending");
          ddr_mem[bus.ddr2_addr[26:4]] = bus.to_ddr2_data;
        end
      end else if (pending && pend_cnt > 0) begin
        pend_cnt--;
      end
      if (pending && pend_cnt == 0) begin
        bus.ddr2_data      = ddr_line(fill_addr_obs[26:4]);
        bus.ddr2_available = 1'b1;
        pending = 0;
      end

      if (bus.available) begin
        if (prev_avail) fail("avail_pulse", "available high two cycles running");
        if (sb.size() == 0) begin
          fail("spurious_available", "available with no request outstanding");
        end else begin
          e = sb.pop_front();
          if (e.is_load) chk("read_data", bus.read_data, e.data);
          chk("n_writeback", n_wb, (e.kind == 2) ? 1 : 0);
          chk("n_fill", n_fill, (e.kind != 0) ? 1 : 0);
          if (e.kind == 2) chk("wb_addr", wb_addr_obs, e.wb_addr);
          if (e.kind != 0) chk("fill_addr", fill_addr_obs, e.fill_addr);
          chk("latency", cyc - e.accept_cyc + 1, e.lat);
          n_wb = 0;
          n_fill = 0;
          done_cnt++;
        end
        if (!mem_sticky) bus.ddr2_available = 1'b0;
      end
      prev_avail = bus.available;
    end
  end

  // Issue one request, update the model, and wait for its completion.
  // poke_at >= 0 pulses a stray store that many cycles into the wait.
  task automatic issue(input bit [26:0] a, input bit wr, input bit [31:0] d, input int poke_at);
    exp_t e;
    bit [9:0]  idx = a[13:4];
    bit [12:0] tg  = a[26:14];
    bit [24:0] wa  = a[26:2];
    int start;
    e.is_load   = !wr;
    e.data      = '0;
    e.fill_addr = {tg, idx, 4'b0};
    e.wb_addr   = {dir_tag[idx], idx, 4'b0};
    e.wb_line   = '0;
    if (dir_v[idx] && dir_tag[idx] == tg) begin
      e.kind = 0;
    end else if (dir_v[idx] && dir_d[idx]) begin
      e.kind = 2;
      for (int w = 0; w < 4; w++) begin
        e.wb_line[32*w +: 32] = ref_word({dir_tag[idx], idx, 2'(w)});
        exp_mem[{dir_tag[idx], idx, 2'(w)}] = ref_word({dir_tag[idx], idx, 2'(w)});
      end
    end else begin
      e.kind = 1;
    end
    if (e.kind == 0) e.lat = 1;
    else e.lat = ((e.kind == 2) ? 4 : 3) + ((mem_delay > 1) ? mem_delay - 1 : 0);
    if (e.kind != 0) begin
      dir_v[idx] = 1;
      dir_tag[idx] = tg;
      dir_d[idx] = wr;
    end else if (wr) begin
      dir_d[idx] = 1;
    end
    if (wr) ref_mem[wa] = d;
    else e.data = ref_word(wa);

    @(posedge clk); #1;
    e.accept_cyc = cyc + 1;
    sb.push_back(e);
    start = done_cnt;
    bus.addr = a; bus.write = wr; bus.write_data = d; bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    for (int t = 0; t < 400 && done_cnt == start; t++) begin
      @(negedge clk);
      if (t == poke_at) begin
        bus.addr = 27'd200; bus.write = 1'b1; bus.write_data = 32'hDEAD_BEEF; bus.enable = 1'b1;
      end else begin
        bus.enable = 1'b0;
      end
    end
    bus.enable = 1'b0;
    if (done_cnt == start) begin
      fail("timeout", $sformatf("no available for addr %0d", a));
      sb.delete();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      if (dir_v[i] && dir_d[i])
        for (int w = 0; w < 4; w++)
          ref_mem[{dir_tag[i], 10'(i), 2'(w)}] = exp_word({dir_tag[i], 10'(i), 2'(w)});
      dir_v[i] = 0;
      dir_d[i] = 0;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_read_data"},    bus.read_data, 0);
    chk({tag, "_available"},    bus.available, 0);
    chk({tag, "_ddr2_enable"},  bus.ddr2_enable, 0);
    chk({tag, "_ddr2_read"},    bus.ddr2_read, 0);
    chk({tag, "_ddr2_addr"},    bus.ddr2_addr, 0);
    chk({tag, "_to_ddr2_data"}, bus.to_ddr2_data, 0);
  endtask

  initial begin
    bit [26:0] a;
    bus.addr = '0; bus.write_data = '0; bus.write = 1'b0; bus.enable = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Directed sequence: cold store miss, hits, conflict eviction, reload.
    issue(27'd100,   1, 32'd100,   -1);
    issue(27'd104,   1, 32'd104,   -1);
    issue(27'd100,   0, 32'd0,     -1);
    issue(27'd104,   0, 32'd0,     -1);
    issue(27'd16484, 1, 32'd16484, -1);
    issue(27'd100,   0, 32'd0,     -1);
    issue(27'd104,   0, 32'd0,     -1);

    // Stray enable during FILL_WAIT must be dropped; address 200 stays untouched.
    mem_delay = 6;
    issue(27'd16496, 0, 32'd0, 3);
    mem_delay = 0;
    issue(27'd200, 0, 32'd0, -1);

    // Permanently high ddr2_available: each miss still needs its own fill.
    mem_sticky = 1;
    issue(27'd16484, 0, 32'd0, -1);
    issue(27'd100,   1, 32'd7,  -1);
    issue(27'd16488, 0, 32'd0, -1);
    issue(27'd100,   0, 32'd0, -1);
    mem_sticky = 0;

    // Reset in the middle of a miss aborts it; next access misses again.
    mem_delay = 20;
    @(posedge clk); #1;
    bus.addr = 27'd112; bus.write = 1'b1; bus.write_data = 32'd77; bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("abort");
    model_reset();
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_delay = 0;
    issue(27'd112, 0, 32'd0, -1);
    issue(27'd100, 0, 32'd0, -1);

    // Random traffic over a few conflicting lines.
    for (int n = 0; n < 200; n++) begin
      mem_sticky = ($urandom_range(0, 3) == 0);
      mem_delay  = mem_sticky ? 0 : int'($urandom_range(0, 4));
      a = {13'($urandom_range(0, 3)), 10'($urandom_range(20, 23)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      issue(a, 1'($urandom_range(0, 1)), $urandom, -1);
    end

    repeat (5) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
